mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter FAIR_LIMIT, default 2, max consecutive data grants while an instruction request waits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 if_req  input  1  instruction-fetch request; held high until if_done.
REQ-005 if_addr  input  8  fetch byte address; bits [1:0] ignored; held stable while if_req high.
REQ-006 if_done  output  1  one-cycle pulse; fetch complete, if_rdata valid in same cycle.
REQ-007 if_rdata  output  32  fetched instruction word.
REQ-008 d_req  input  1  data request; held high until d_done.
REQ-009 d_we  input  1  1 = store word, 0 = load word.
REQ-010 d_addr  input  8  data byte address; held stable while d_req high.
REQ-011 d_wdata  input  32  store data.
REQ-012 d_done  output  1  one-cycle pulse; data access complete.
REQ-013 d_rdata  output  32  load data; 0 on stores and on misaligned accesses.
REQ-014 d_err  output  1  valid with d_done; 1 = misaligned access (d_addr[1:0] != 0).
REQ-015 mem_en  output  1  memory access strobe, registered.
REQ-016 mem_we  output  1  memory write enable, registered.
REQ-017 mem_addr  output  6  word address (requester addr[7:2]), registered.
REQ-018 mem_wdata  output  32  write data, registered.
REQ-019 mem_rdata  input  32  read data, valid the cycle after mem_en (synchronous 64x32 single-port memory).

Function
REQ-020 Block SHALL share one single-port 64-word memory between fetch and data ports, with at most one memory access in flight.
REQ-021 FSM SHALL have states IDLE, ISSUE, RESP, with an owner register OWN (IF or D) written on each grant.
REQ-022 IDLE: no request -> stay; on a grant -> ISSUE.
REQ-023 ISSUE lasts exactly one cycle, with mem_en=1, mem_addr/mem_we/mem_wdata from the owner (mem_we=0 for IF); then -> RESP.
REQ-024 RESP lasts one cycle: owner's done=1; IF: if_rdata=mem_rdata; D load: d_rdata=mem_rdata; D store: d_rdata=0.
REQ-025 RESP exit: -> ISSUE if a request other than the just-completed one is pending, else IDLE; the completed requester's req is ignored in the RESP cycle (back-to-back: one access per 2 cycles).
REQ-026 Latency, uncontended: req high at edge k -> ISSUE in cycle k+1 -> done in cycle k+2.
REQ-027 Arbitration when both requests are pending: data port wins unless fair_cnt == FAIR_LIMIT, in which case IF wins.
REQ-028 fair_cnt (2-bit, saturating) SHALL increment on each D grant while if_req=1 and clear on each IF grant or whenever if_req=0.
REQ-029 Misaligned data request (d_addr[1:0] != 0): when granted, no ISSUE and no mem_en; next cycle d_done=1, d_err=1, d_rdata=0; counts as a D grant.
REQ-030 Fetch address bits [1:0] SHALL be ignored; fetches never error.
REQ-031 mem_en, mem_we, if_done and d_done SHALL be 0 outside the cycles defined above; if_rdata and d_rdata SHALL be 0 when their done is 0.
REQ-032 Outputs SHALL be registered or decoded from state only; no combinational path from req inputs to mem_* outputs.

Reset
REQ-033 rst_n=0 SHALL asynchronously force: state IDLE, OWN=IF, fair_cnt=0, and all outputs 0.
REQ-034 Reset asserted in ISSUE or RESP SHALL abort the access: no done pulse, and any pending store is dropped if mem_en has not yet been sampled.
REQ-035 After rst_n rises, the first grant occurs at the first rising edge at which a request is high.

Verification
REQ-036 if_req=1, if_addr=0x08, mem returns 0x00000033 -> mem_en with mem_addr=2 at k+1; if_done=1 and if_rdata=0x00000033 at k+2.
REQ-037 d_req=1, d_we=1, d_addr=0x0C, d_wdata=0xDEADBEEF -> mem_we=1, mem_addr=3, mem_wdata=0xDEADBEEF; d_done=1 with d_rdata=0 and d_err=0.
REQ-038 if_req and d_req both held continuously -> grant order D,D,IF,D,D,IF with FAIR_LIMIT=2; no two done pulses in the same cycle.
REQ-039 d_req=1, d_addr=0x05 -> no mem_en; d_done=1 and d_err=1 one cycle after the grant.
REQ-040 rst_n pulled low during ISSUE of a load -> all outputs 0 immediately, no d_done; after release a re-requested load completes normally with the k+2 latency.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the memory arbiter, its two requesters and the memory.
// slave: the arbiter's view; master: requesters plus memory.
interface mem_arbiter_if;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_done;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [7:0]  d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic        d_err;
  logic        mem_en;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_done, if_rdata, d_done, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_done, if_rdata, d_done, d_rdata, d_err,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port 64x32 memory between an instruction-fetch port and
// a data port; data wins contention until FAIR_LIMIT grants starve a fetch.
//
// state   | meaning
// S_IDLE  | no access in flight, any request may be granted
// S_ISSUE | memory strobe for the owner's access is on the bus
// S_RESP  | owner's done pulse; read data comes straight from the memory
module mem_arbiter #(
  parameter int unsigned FAIR_LIMIT = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_RESP = 2'd2} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} own_t;

  state_t      r_state, w_state_nxt;
  own_t        r_own, w_own_nxt;
  logic [1:0]  r_fair_cnt, w_fair_nxt;
  logic        r_we, w_we_nxt;
  logic        r_err, w_err_nxt;
  logic        r_mem_en, w_mem_en_nxt;
  logic        r_mem_we, w_mem_we_nxt;
  logic [5:0]  r_mem_addr, w_mem_addr_nxt;
  logic [31:0] r_mem_wdata, w_mem_wdata_nxt;
  logic        w_may_grant, w_grant_d, w_grant_if;
  logic        w_d_misal, w_fair_hit;
  logic        w_if_done, w_d_done;
  logic        w_unused_bits;

  assign w_d_misal     = (bus.d_addr[1:0] != 2'b00);
  assign w_fair_hit    = (32'(r_fair_cnt) == FAIR_LIMIT);
  assign w_unused_bits = ^bus.if_addr[1:0];

  always_comb begin
    w_may_grant     = 1'b0;
    w_state_nxt     = r_state;
    w_own_nxt       = r_own;
    w_we_nxt        = r_we;
    w_err_nxt       = r_err;
    w_fair_nxt      = r_fair_cnt;
    w_mem_en_nxt    = 1'b0;
    w_mem_we_nxt    = 1'b0;
    w_mem_addr_nxt  = 6'd0;
    w_mem_wdata_nxt = 32'd0;

    // In RESP the completed requester cannot hold the bus on its own; only a
    // waiting peer reopens arbitration, which then sees both requests.
    case (r_state)
      S_IDLE:  w_may_grant = 1'b1;
      S_RESP:  w_may_grant = (r_own == OWN_D) ? bus.if_req : bus.d_req;
      default: w_may_grant = 1'b0;
    endcase

    w_grant_d  = w_may_grant && bus.d_req && !(bus.if_req && w_fair_hit);
    w_grant_if = w_may_grant && bus.if_req && !w_grant_d;

    if (!bus.if_req || w_grant_if)
      w_fair_nxt = 2'd0;
    else if (w_grant_d && (r_fair_cnt != 2'd3))
      w_fair_nxt = r_fair_cnt + 2'd1;

    if (w_grant_d) begin
      w_own_nxt = OWN_D;
      w_we_nxt  = bus.d_we;
      w_err_nxt = w_d_misal;
      if (w_d_misal) begin
        w_state_nxt = S_RESP;
      end else begin
        w_state_nxt     = S_ISSUE;
        w_mem_en_nxt    = 1'b1;
        w_mem_we_nxt    = bus.d_we;
        w_mem_addr_nxt  = bus.d_addr[7:2];
        w_mem_wdata_nxt = bus.d_we ? bus.d_wdata : 32'd0;
      end
    end else if (w_grant_if) begin
      w_own_nxt      = OWN_IF;
      w_we_nxt       = 1'b0;
      w_err_nxt      = 1'b0;
      w_state_nxt    = S_ISSUE;
      w_mem_en_nxt   = 1'b1;
      w_mem_addr_nxt = bus.if_addr[7:2];
    end else begin
      case (r_state)
        S_ISSUE: w_state_nxt = S_RESP;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_own       <= OWN_IF;
      r_fair_cnt  <= 2'd0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 6'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_own       <= w_own_nxt;
      r_fair_cnt  <= w_fair_nxt;
      r_we        <= w_we_nxt;
      r_err       <= w_err_nxt;
      r_mem_en    <= w_mem_en_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
    end
  end

  assign w_if_done = (r_state == S_RESP) && (r_own == OWN_IF);
  assign w_d_done  = (r_state == S_RESP) && (r_own == OWN_D);

  assign bus.if_done   = w_if_done;
  assign bus.if_rdata  = w_if_done ? bus.mem_rdata : 32'd0;
  assign bus.d_done    = w_d_done;
  assign bus.d_err     = w_d_done && r_err;
  assign bus.d_rdata   = (w_d_done && !r_we && !r_err) ? bus.mem_rdata : 32'd0;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
endmodule
